// File: rtl/axil_stream_tx.sv
// AXI4-Lite register front end that pushes DATA writes into a FIFO and emits them on an AXI4-Stream master with LEN-based TLAST.
// Latency: TVALID 2 cycles after the write handshake; TREADY low stalls the output beat, and a DATA write to a full FIFO is dropped with SLVERR.
module axil_stream_tx #(
  parameter int C_S_AXI_DATA_WIDTH   = 32,
  parameter int C_S_AXI_ADDR_WIDTH   = 4,
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH           = 8
) (
  input  logic                                ACLK,
  input  logic                                ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_AWADDR,
  input  logic [2:0]                          S_AXI_AWPROT,
  input  logic                                S_AXI_AWVALID,
  output logic                                S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]     S_AXI_WSTRB,
  input  logic                                S_AXI_WVALID,
  output logic                                S_AXI_WREADY,
  output logic [1:0]                          S_AXI_BRESP,
  output logic                                S_AXI_BVALID,
  input  logic                                S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_ARADDR,
  input  logic [2:0]                          S_AXI_ARPROT,
  input  logic                                S_AXI_ARVALID,
  output logic                                S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_RDATA,
  output logic [1:0]                          S_AXI_RRESP,
  output logic                                S_AXI_RVALID,
  input  logic                                S_AXI_RREADY,
  output logic                                M_AXIS_TVALID,
  input  logic                                M_AXIS_TREADY,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
  output logic                                M_AXIS_TLAST
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic          awready_q, awready_d;
  logic          bvalid_q, bvalid_d;
  logic [1:0]    bresp_q, bresp_d;
  logic          arready_q, arready_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [DW-1:0] ctrl_q, ctrl_d;
  logic [DW-1:0] scratch_q, scratch_d;
  logic [DW-1:0] last_data_q, last_data_d;
  logic          ovf_q, ovf_d;
  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [DW-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          tvalid_q, tvalid_d;
  logic [C_M_AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic          tlast_q, tlast_d;
  logic [3:0]    beat_cnt_q, beat_cnt_d;
  logic [3:0]    len_lat_q, len_lat_d;

  logic          wr_en, rd_en, push, pop, full, empty, last_beat;
  logic [1:0]    wr_sel, rd_sel;
  logic [3:0]    cur_len;
  logic [DW-1:0] status_w;
  logic          unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  always_comb begin
    wr_sel    = S_AXI_AWADDR[3:2];
    rd_sel    = S_AXI_ARADDR[3:2];
    full      = (count_q == CW'(FIFO_DEPTH));
    empty     = (count_q == '0);
    wr_en     = awready_q && S_AXI_AWVALID && S_AXI_WVALID;
    rd_en     = arready_q && S_AXI_ARVALID;
    push      = wr_en && (wr_sel == 2'd0) && !full;
    pop       = ctrl_q[0] && !empty && (!tvalid_q || M_AXIS_TREADY);
    status_w  = '0;
    status_w[8 +: CW] = count_q;
    status_w[2:0] = {ovf_q, full, empty};

    awready_d   = S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !awready_q;
    arready_d   = S_AXI_ARVALID && !rvalid_q && !arready_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    rvalid_d    = rvalid_q;
    rdata_d     = rdata_q;
    ctrl_d      = ctrl_q;
    scratch_d   = scratch_q;
    last_data_d = last_data_q;
    ovf_d       = ovf_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    tlast_d     = tlast_q;
    beat_cnt_d  = beat_cnt_q;
    len_lat_d   = len_lat_q;
    cur_len     = (beat_cnt_q == 4'd0) ? ctrl_q[7:4] : len_lat_q;
    last_beat   = (beat_cnt_q == cur_len);

    if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
    if (wr_en) begin
      bvalid_d = 1'b1;
      bresp_d  = ((wr_sel == 2'd0) && full) ? 2'b10 : 2'b00;
      case (wr_sel)
        2'd0: if (full) ovf_d = 1'b1;
        2'd1: for (int b = 0; b < SW; b++)
                if (S_AXI_WSTRB[b]) ctrl_d[8*b +: 8] = S_AXI_WDATA[8*b +: 8];
        2'd2: if (S_AXI_WSTRB[0] && S_AXI_WDATA[2]) ovf_d = 1'b0;
        default: for (int b = 0; b < SW; b++)
                if (S_AXI_WSTRB[b]) scratch_d[8*b +: 8] = S_AXI_WDATA[8*b +: 8];
      endcase
    end
    if (push) begin
      mem_d[wr_ptr_q] = S_AXI_WDATA;
      last_data_d     = S_AXI_WDATA;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end

    // Registers are read before this cycle's write lands, so STATUS shows the pre-write value.
    if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
    if (rd_en) begin
      rvalid_d = 1'b1;
      case (rd_sel)
        2'd0:    rdata_d = last_data_q;
        2'd1:    rdata_d = ctrl_q;
        2'd2:    rdata_d = status_w;
        default: rdata_d = scratch_q;
      endcase
    end

    // The beat counter advances when a beat is committed to the output register;
    // a committed beat is always delivered, so this tracks stream handshakes.
    if (tvalid_q && M_AXIS_TREADY) tvalid_d = 1'b0;
    if (pop) begin
      tvalid_d   = 1'b1;
      tdata_d    = mem_q[rd_ptr_q];
      tlast_d    = last_beat;
      len_lat_d  = cur_len;
      beat_cnt_d = last_beat ? 4'd0 : beat_cnt_q + 4'd1;
      rd_ptr_d   = rd_ptr_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      awready_q   <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= 2'b00;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      ctrl_q      <= DW'(32'h0000_0070);
      scratch_q   <= '0;
      last_data_q <= '0;
      ovf_q       <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tlast_q     <= 1'b0;
      beat_cnt_q  <= 4'd0;
      len_lat_q   <= 4'd0;
    end else begin
      awready_q   <= awready_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      ctrl_q      <= ctrl_d;
      scratch_q   <= scratch_d;
      last_data_q <= last_data_d;
      ovf_q       <= ovf_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tlast_q     <= tlast_d;
      beat_cnt_q  <= beat_cnt_d;
      len_lat_q   <= len_lat_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TLAST  = tlast_q;
  assign M_AXIS_TSTRB  = '1;

endmodule

// File: tb/tb_axil_stream_tx.sv
// Directed bench for axil_stream_tx: register access, packetizing, overflow, random backpressure and mid-packet reset.
module tb_axil_stream_tx;

  logic        aclk, aresetn;
  logic [3:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, arvalid, arready, rvalid;
  logic [31:0] wdata, rdata, tdata;
  logic [3:0]  wstrb, tstrb;
  logic [1:0]  bresp, rresp;
  logic        tvalid, tready, tlast;
  logic        tready_set, tready_rnd, rnd_mode;

  int n_pass = 0, n_total = 0;
  int cyc = 0, last_hs_cyc = 0, first_tv_cyc = -1;
  logic [31:0] bq_data[$];
  logic        bq_last[$];
  logic        prev_stall = 1'b0, prev_last;
  logic [31:0] prev_data;

  assign tready = rnd_mode ? tready_rnd : tready_set;

  axil_stream_tx dut (
    .ACLK(aclk), .ARESETN(aresetn),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(1'b1),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(1'b1),
    .M_AXIS_TVALID(tvalid), .M_AXIS_TREADY(tready), .M_AXIS_TDATA(tdata),
    .M_AXIS_TSTRB(tstrb), .M_AXIS_TLAST(tlast)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  always @(posedge aclk) cyc <= cyc + 1;

  always @(posedge aclk) begin
    #1;
    tready_rnd = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Stream monitor: records delivered beats and enforces AXIS hold while stalled.
  always @(negedge aclk) begin
    if (!aresetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("tvalid_hold", {31'b0, tvalid}, 32'd1);
        chk("tdata_hold", tdata, prev_data);
        chk("tlast_hold", {31'b0, tlast}, {31'b0, prev_last});
      end
      if (tvalid && first_tv_cyc < 0) first_tv_cyc = cyc;
      if (tvalid && tready) begin
        bq_data.push_back(tdata);
        bq_last.push_back(tlast);
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
    end
  end

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n;
    @(posedge aclk); #1;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (!awready && n < 50);
    chk("aw_handshake", {31'b0, awready && wready}, 32'd1);
    last_hs_cyc = cyc;
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge aclk); n++; end
    chk("bvalid", {31'b0, bvalid}, 32'd1);
    resp = bresp;
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    @(posedge aclk); #1;
    araddr = addr; arvalid = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (!arready && n < 50);
    @(posedge aclk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin @(negedge aclk); n++; end
    chk("rvalid", {31'b0, rvalid}, 32'd1);
    data = rdata;
    resp = rresp;
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k;
    k = 0;
    while (bq_data.size() < n && k < budget) begin @(negedge aclk); k++; end
    repeat (6) @(negedge aclk);
    chk("beat_count", bq_data.size(), n);
  endtask

  task automatic chk_beats(input logic [31:0] base, input int n, input int len);
    for (int i = 0; i < n && i < bq_data.size(); i++) begin
      chk("beat_data", bq_data[i], base + 32'(i));
      chk("beat_last", {31'b0, bq_last[i]}, {31'b0, ((i % (len + 1)) == len)});
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rsp;
    int          t0;
    aresetn = 1'b0; awaddr = '0; araddr = '0; awvalid = 1'b0; wvalid = 1'b0;
    wdata = '0; wstrb = '0; arvalid = 1'b0; tready_set = 1'b0; rnd_mode = 1'b0;

    // Reset state
    repeat (3) @(negedge aclk);
    chk("rst_tvalid", {31'b0, tvalid}, 32'd0);
    chk("rst_bvalid", {31'b0, bvalid}, 32'd0);
    chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
    chk("rst_awready", {31'b0, awready}, 32'd0);
    chk("rst_tdata", tdata, 32'd0);
    chk("rst_tstrb", {28'b0, tstrb}, 32'hF);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    axi_read(4'h4, rd, rsp); chk("rst_ctrl", rd, 32'h70);
    axi_read(4'h8, rd, rsp); chk("rst_status", rd, 32'h1);
    axi_read(4'hC, rd, rsp); chk("rst_scratch", rd, 32'h0);

    // Scratch with partial strobes
    axi_write(4'hC, 32'hbeef0011, 4'b0011, rsp); chk("scratch_bresp", {30'b0, rsp}, 32'd0);
    axi_read(4'hC, rd, rsp);
    chk("scratch_rd", rd, 32'h0000_0011);
    chk("scratch_rresp", {30'b0, rsp}, 32'd0);

    // LEN=3 packets at full rate, first-word latency
    tready_set = 1'b1;
    axi_write(4'h4, 32'h31, 4'hF, rsp);
    bq_data.delete(); bq_last.delete(); first_tv_cyc = -1;
    axi_write(4'h0, 32'h1, 4'hF, rsp);
    t0 = last_hs_cyc;
    for (int i = 2; i <= 8; i++) axi_write(4'h0, 32'(i), 4'hF, rsp);
    wait_beats(8, 100);
    chk("first_latency", 32'(first_tv_cyc - t0), 32'd2);
    chk_beats(32'h1, 8, 3);

    // Overflow with stream disabled
    axi_write(4'h4, 32'h30, 4'hF, rsp);
    bq_data.delete(); bq_last.delete();
    for (int i = 0; i < 8; i++) axi_write(4'h0, 32'h10 + 32'(i), 4'hF, rsp);
    chk("eighth_bresp", {30'b0, rsp}, 32'd0);
    axi_write(4'h0, 32'h18, 4'hF, rsp);
    chk("ninth_bresp", {30'b0, rsp}, 32'd2);
    axi_read(4'h8, rd, rsp); chk("status_ovf", rd, 32'h0000_0806);
    axi_read(4'h0, rd, rsp); chk("last_data", rd, 32'h17);
    axi_write(4'h8, 32'h4, 4'hF, rsp);
    axi_read(4'h8, rd, rsp); chk("status_ovf_clr", rd, 32'h0000_0802);
    axi_write(4'h4, 32'h31, 4'hF, rsp);
    wait_beats(8, 100);
    chk_beats(32'h10, 8, 3);
    axi_read(4'h8, rd, rsp); chk("status_drained", rd, 32'h1);

    // Random backpressure, LEN=2
    axi_write(4'h4, 32'h21, 4'hF, rsp);
    bq_data.delete(); bq_last.delete();
    rnd_mode = 1'b1;
    for (int i = 0; i < 12; i++) axi_write(4'h0, 32'h100 + 32'(i), 4'hF, rsp);
    wait_beats(12, 400);
    rnd_mode = 1'b0;
    chk_beats(32'h100, 12, 2);

    // Reset mid-packet with 3 words queued
    tready_set = 1'b0;
    axi_write(4'h4, 32'h71, 4'hF, rsp);
    for (int i = 0; i < 3; i++) axi_write(4'h0, 32'h200 + 32'(i), 4'hF, rsp);
    @(negedge aclk);
    chk("pre_rst_tvalid", {31'b0, tvalid}, 32'd1);
    chk("pre_rst_tdata", tdata, 32'h200);
    @(posedge aclk); #2;
    aresetn = 1'b0;
    #1;
    chk("mid_rst_tvalid", {31'b0, tvalid}, 32'd0);
    chk("mid_rst_tdata", tdata, 32'd0);
    chk("mid_rst_tlast", {31'b0, tlast}, 32'd0);
    repeat (2) @(negedge aclk);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    axi_read(4'h8, rd, rsp); chk("post_rst_status", rd, 32'h1);
    axi_read(4'h4, rd, rsp); chk("post_rst_ctrl", rd, 32'h70);
    bq_data.delete(); bq_last.delete();
    axi_write(4'h4, 32'h71, 4'hF, rsp);
    tready_set = 1'b1;
    for (int i = 0; i < 8; i++) axi_write(4'h0, 32'h300 + 32'(i), 4'hF, rsp);
    wait_beats(8, 100);
    chk_beats(32'h300, 8, 7);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axil_stream_tx.md
Name: axil_stream_tx

Overview:
- AXI4-Lite slave register block that acts as an AXI4-Stream transmitter.
- Software writes data words over AXI4-Lite; each word is pushed into an internal FIFO.
- Words are emitted on a master AXI4-Stream port, with TLAST marking programmable packet boundaries.
- Provides the memory-mapped control/status front end for stream producers in the block design, driven by the lite master BFM and observed by the streaming slave BFM.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI4-Lite data width (fixed 32)
C_S_AXI_ADDR_WIDTH, 4, AXI4-Lite address width (4 word registers)
C_M_AXIS_TDATA_WIDTH, 32, stream data width (equals lite data width)
FIFO_DEPTH, 8, FIFO entries, power of two, 2..64

Ports:
ACLK  in  1  single clock, all logic on rising edge
ARESETN  in  1  reset, asynchronous assert, active-low
S_AXI_AWADDR  in  4  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write address handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID / S_AXI_WREADY  in / out  1  write data handshake
S_AXI_BRESP  out  2  write response
S_AXI_BVALID / S_AXI_BREADY  out / in  1  write response handshake
S_AXI_ARADDR  in  4  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read address handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID / S_AXI_RREADY  out / in  1  read data handshake
M_AXIS_TVALID / M_AXIS_TREADY  out / in  1  stream handshake
M_AXIS_TDATA  out  32  stream data
M_AXIS_TSTRB  out  4  constant 4'hF
M_AXIS_TLAST  out  1  last beat of packet

Behaviour:
- Reset (ARESETN=0, asynchronous): all READY/VALID outputs 0; BRESP, RRESP, RDATA, TDATA, TLAST 0; FIFO empty; beat counter 0; CTRL = 0x0000_0070 (enable=0, LEN=7); SCRATCH 0; overflow 0. Reset mid-transfer drops all FIFO content and pending responses.
- Register map (ADDR[3:2]); ADDR[1:0] ignored:
  - 0x0 DATA, WO push. Reads return the last accepted DATA word.
  - 0x4 CTRL: bit0 ENABLE; bits[7:4] LEN, packet length = LEN+1 (1..16).
  - 0x8 STATUS, RO: [15:8] FIFO count; bit2 overflow (sticky); bit1 full; bit0 empty. Writing 1 to bit2 clears overflow.
  - 0xC SCRATCH, RW with WSTRB.
- Write channel: AWREADY and WREADY pulse together for one cycle when AWVALID & WVALID & !BVALID.
  - BVALID asserts the next cycle and holds until BREADY.
  - AW or W arriving alone waits; no data is stored.
- Write response: BRESP=2'b00 OKAY. A DATA write while full is dropped, sets overflow, BRESP=2'b10 SLVERR.
  - DATA push ignores WSTRB (full word). CTRL/SCRATCH honour WSTRB per byte.
- Read channel: ARREADY pulses one cycle when ARVALID & !RVALID. RVALID plus RDATA the next cycle, held until RREADY. RRESP always 2'b00.
- Read/write ordering: independent. A same-cycle read of STATUS returns the pre-write value.
- FIFO:
  - Push on the write handshake cycle; count updates the following cycle.
  - Full is judged on registered count. Push at full is rejected even if a pop occurs the same cycle.
  - Simultaneous push and pop when not full: count unchanged.
- Stream:
  - TVALID rises the cycle after the FIFO becomes non-empty, provided ENABLE=1.
  - First word latency: 2 cycles after the write handshake.
  - Once TVALID=1, TVALID, TDATA and TLAST hold stable until TREADY (AXIS rule). Clearing ENABLE only blocks starting the next beat.
  - Back-to-back beats at full rate when TREADY stays high and the FIFO is non-empty.
- Packetizer:
  - The beat counter increments on each TVALID&TREADY.
  - TLAST=1 when counter == latched LEN; counter wraps to 0 after the TLAST beat.
  - LEN is latched at the first beat of each packet. A CTRL write mid-packet takes effect from the next packet.
  - Packets are not padded: with fewer words available, TVALID stays low until more data arrives.

Test Plan:
- Reset, then read 0x4, 0x8, 0xC -> 0x70, 0x00000001, 0x0; TVALID=0; BVALID=RVALID=0.
- Write SCRATCH 0xbeef0011 with WSTRB=4'b0011, read back -> 0x00000011, BRESP=RRESP=OKAY.
- CTRL=0x31 (LEN=3, enable); write DATA 0x01..0x08 with TREADY=1 -> 8 beats 0x01..0x08 in order, TLAST on beats 4 and 8; first TVALID 2 cycles after the first write handshake.
- ENABLE=0; write 9 words with FIFO_DEPTH=8 -> 9th BRESP=SLVERR, STATUS=0x00000806. Write 0x4 to STATUS -> overflow clears. Set ENABLE -> exactly 8 words out.
- TREADY toggled randomly 50% -> TDATA/TLAST stable while TVALID&!TREADY, no loss or duplication.
- Assert ARESETN=0 mid-packet with 3 words queued -> outputs 0 immediately. After release: STATUS=0x00000001, CTRL=0x70, next packet TLAST follows LEN=7 (8th beat).
